nvdla_apb2csb_bridge_v2: RTL

//  Next-generation APB-to-CSB bridge between the host APB config port and the NVDLA core CSB slave.

---
 rtl/nvdla_apb2csb_bridge_v2.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/nvdla_apb2csb_bridge_v2.sv
// APB-to-CSB bridge with one outstanding CSB transaction, decode/alignment/timeout errors and PSLVERR.
// Latency: posted write with ready high completes two cycles after capture; reads complete one cycle after response.
module nvdla_apb2csb_bridge_v2 #(
   parameter int CSB_AW     = 16,
   parameter int TIMEOUT    = 1024,
   parameter int NPOSTED_WR = 0,
   parameter int ERR_W      = 8
) (
   input  logic              csb_clk,
   input  logic              csb_rstn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [31:0]       paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              csb2nvdla_valid,
   input  logic              csb2nvdla_ready,
   output logic [CSB_AW-1:0] csb2nvdla_addr,
   output logic [31:0]       csb2nvdla_wdat,
   output logic              csb2nvdla_write,
   output logic              csb2nvdla_nposted,
   input  logic              nvdla2csb_valid,
   input  logic [31:0]       nvdla2csb_data,
   input  logic              nvdla2csb_wr_complete,
   output logic [ERR_W-1:0]  err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_RD,
      S_WAIT_WR,
      S_DONE
   } state_t;

   localparam int              CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic            NP      = (NPOSTED_WR != 0);
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic [CSB_AW-1:0]  addr_q, addr_d;
   logic [31:0]        wdat_q, wdat_d;
   logic               write_q, write_d;
   logic               nposted_q, nposted_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

   logic               bad_addr;
   logic               timed_out;

   assign bad_addr  = (paddr[1:0] != 2'b00) || ((paddr >> (CSB_AW + 2)) != 32'd0);
   // >= rather than == so an accept on the last REQ cycle still times out in WAIT
   assign timed_out = (cnt_q >= TO_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      addr_d    = addr_q;
      wdat_d    = wdat_q;
      write_d   = write_q;
      nposted_d = nposted_q;
      rdata_d   = rdata_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            err_d = 1'b0;
            if (psel && penable) begin
               addr_d    = paddr[CSB_AW+1:2];
               wdat_d    = pwdata;
               write_d   = pwrite;
               nposted_d = pwrite & NP;
               rdata_d   = '0;
               if (bad_addr) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (csb2nvdla_ready) begin
               if (!write_q)    state_d = S_WAIT_RD;
               else if (NP)     state_d = S_WAIT_WR;
               else             state_d = S_DONE;
            end else if (timed_out) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_WAIT_RD: begin
            cnt_d = cnt_q + 1'b1;
            if (nvdla2csb_valid) begin
               rdata_d = nvdla2csb_data;
               state_d = S_DONE;
            end else if (timed_out) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_WAIT_WR: begin
            cnt_d = cnt_q + 1'b1;
            if (nvdla2csb_wr_complete) begin
               state_d = S_DONE;
            end else if (timed_out) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
            cnt_d   = '0;
            if (err_q && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge csb_clk or negedge csb_rstn) begin
      if (!csb_rstn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wdat_q    <= '0;
         write_q   <= 1'b0;
         nposted_q <= 1'b0;
         rdata_q   <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         wdat_q    <= wdat_d;
         write_q   <= write_d;
         nposted_q <= nposted_d;
         rdata_q   <= rdata_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign pready            = (state_q == S_DONE);
   assign pslverr           = pready & err_q;
   assign prdata            = (pready && !err_q && !write_q) ? rdata_q : 32'd0;
   assign csb2nvdla_valid   = (state_q == S_REQ);
   assign csb2nvdla_addr    = addr_q;
   assign csb2nvdla_wdat    = wdat_q;
   assign csb2nvdla_write   = write_q;
   assign csb2nvdla_nposted = nposted_q;
   assign err_cnt           = err_cnt_q;

endmodule
